alsu_bist_ctrl: RTL and testbench

ALSU_BIST_CTRL -- requirements
Module: alsu_bist_ctrl

---
 rtl/alsu_bist_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_alsu_bist_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_bist_ctrl.sv
// ---------------------------------------------------------------------------
// alsu_bist_ctrl
//   Built-in self-test sequencer for a 3-bit ALSU. One accepted start runs
//   four opcode phases (AND, XOR, ADD, MUL) of NUM_VECTORS pseudo-random
//   vectors each. Every vector is driven, given LATENCY cycles to propagate,
//   then checked against a locally computed expected value. A saturating
//   mismatch count and the first failing vector are reported.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             single-cycle run request (ignored while busy)
//   busy, done, pass  run in progress / run complete (held) / done with 0 errors
//   err_cnt           saturating mismatch count
//   fail_op/a/b       opcode and operands of the first mismatch of the run
//   alsu_rst          active-high reset to the ALSU, asserted outside a run
//   A, B, opcode, cin registered stimulus to the ALSU
//   serial_in .. bypass_B  unused ALSU controls, tied low
//   alsu_out          ALSU result
// ---------------------------------------------------------------------------
module alsu_bist_ctrl #(
  parameter int    NUM_VECTORS = 100,
  parameter int    LATENCY     = 2,
  parameter string FULL_ADDER  = "ON"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [2:0] fail_op,
  output logic [2:0] fail_a,
  output logic [2:0] fail_b,
  output logic       alsu_rst,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic [2:0] opcode,
  output logic       cin,
  output logic       serial_in,
  output logic       direction,
  output logic       red_op_A,
  output logic       red_op_B,
  output logic       bypass_A,
  output logic       bypass_B,
  input  logic [5:0] alsu_out
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_e;

  localparam logic [9:0] VecLast  = 10'(NUM_VECTORS - 1);
  // WAIT covers LATENCY-1 cycles; the counter runs 0..LATENCY-2.
  localparam logic [2:0] WaitLast = 3'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam bit         UseCin   = (FULL_ADDER == "ON");
  localparam logic [5:0] LfsrSeed = 6'h01;

  state_e     state_q, state_d;
  logic [5:0] lfsr_q, lfsr_d;
  logic [9:0] vec_cnt_q, vec_cnt_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [2:0] fail_op_q, fail_op_d, fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic [2:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic       cin_q, cin_d;
  logic       alsu_rst_q, alsu_rst_d;

  logic [3:0] sum;
  logic [5:0] expected;
  logic       mismatch;
  logic       accept_start;

  // Reference result for the vector currently held on A/B/opcode/cin.
  always_comb begin
    sum = 4'(a_q) + 4'(b_q) + (UseCin ? 4'(cin_q) : 4'd0);
    unique case (op_q[1:0])
      2'd0:    expected = {3'b000, a_q & b_q};
      2'd1:    expected = {3'b000, a_q ^ b_q};
      2'd2:    expected = {2'b00, sum};
      default: expected = 6'(a_q) * 6'(b_q);
    endcase
    mismatch = (alsu_out != expected);
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    vec_cnt_d    = vec_cnt_q;
    phase_d      = phase_q;
    wait_cnt_d   = wait_cnt_q;
    err_cnt_d    = err_cnt_q;
    fail_op_d    = fail_op_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    cin_d        = cin_q;
    accept_start = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = DRIVE;
          accept_start = 1'b1;
        end
      end
      DRIVE: begin
        wait_cnt_d = '0;
        state_d    = (LATENCY > 1) ? WAIT : CHECK;
      end
      WAIT: begin
        if (wait_cnt_q == WaitLast) state_d = CHECK;
        else                        wait_cnt_d = wait_cnt_q + 3'd1;
      end
      CHECK: begin
        lfsr_d = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
        // The first-failure capture keys off err_cnt==0, so a mismatch at
        // saturation can never overwrite fail_*.
        if (mismatch && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
          if (err_cnt_q == 8'd0) begin
            fail_op_d = op_q;
            fail_a_d  = a_q;
            fail_b_d  = b_q;
          end
        end
        if (vec_cnt_q == VecLast) begin
          vec_cnt_d = '0;
          phase_d   = phase_q + 2'd1;
          state_d   = (phase_q == 2'd3) ? DONE : DRIVE;
        end else begin
          vec_cnt_d = vec_cnt_q + 10'd1;
          state_d   = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Each run starts from the same seed so results are repeatable.
    if (accept_start) begin
      lfsr_d    = LfsrSeed;
      vec_cnt_d = '0;
      phase_d   = '0;
      err_cnt_d = '0;
      fail_op_d = '0;
      fail_a_d  = '0;
      fail_b_d  = '0;
    end

    // Stimulus is loaded on entry to DRIVE so it is already on the ALSU
    // pins during DRIVE; LATENCY ALSU edges later CHECK sees the result.
    if (state_d == DRIVE) begin
      a_d   = lfsr_d[5:3];
      b_d   = lfsr_d[2:0];
      op_d  = {1'b0, phase_d};
      cin_d = vec_cnt_d[0];
    end

    alsu_rst_d = (state_d == IDLE) || (state_d == DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lfsr_q     <= LfsrSeed;
      vec_cnt_q  <= '0;
      phase_q    <= '0;
      wait_cnt_q <= '0;
      err_cnt_q  <= '0;
      fail_op_q  <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cin_q      <= 1'b0;
      alsu_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      vec_cnt_q  <= vec_cnt_d;
      phase_q    <= phase_d;
      wait_cnt_q <= wait_cnt_d;
      err_cnt_q  <= err_cnt_d;
      fail_op_q  <= fail_op_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cin_q      <= cin_d;
      alsu_rst_q <= alsu_rst_d;
    end
  end

  assign busy      = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_cnt_q == 8'd0);
  assign err_cnt   = err_cnt_q;
  assign fail_op   = fail_op_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign alsu_rst  = alsu_rst_q;
  assign A         = a_q;
  assign B         = b_q;
  assign opcode    = op_q;
  assign cin       = cin_q;
  assign serial_in = 1'b0;
  assign direction = 1'b0;
  assign red_op_A  = 1'b0;
  assign red_op_B  = 1'b0;
  assign bypass_A  = 1'b0;
  assign bypass_B  = 1'b0;

endmodule

// File: tb/tb_alsu_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alsu_bist_ctrl
//   Drives alsu_bist_ctrl against a behavioural ALSU (ideal, +1 corrupted or
//   stuck-at-0 output). A second instance with NUM_VECTORS=1, LATENCY=1
//   covers the shortest run.
// ---------------------------------------------------------------------------
module tb_alsu_bist_ctrl;

  localparam int N      = 100;
  localparam int L      = 2;
  localparam int RUN    = 4 * N * (L + 1) + 1;
  localparam int BUDGET = 2000;

  typedef struct {
    logic [2:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic       c;
  } vec_t;

  typedef struct {
    int         cycles;
    logic       pass;
    logic [7:0] err;
    logic [2:0] fop;
    logic [2:0] fa;
    logic [2:0] fb;
  } res_t;

  typedef struct {
    int   mode;    // 0 ideal, 1 result+1, 2 stuck at 0
    bit   pulses;  // extra start pulses while busy
    res_t exp;
  } tc_t;

  logic clk = 1'b0;
  logic rst, start, start_s;
  int   mode;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // main instance
  logic       busy, done, pass, alsu_rst, cin;
  logic [7:0] err_cnt;
  logic [2:0] fail_op, fail_a, fail_b, A, B, opcode;
  logic       serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0] alsu_out;

  // small instance
  logic       busy_s, done_s, pass_s, alsu_rst_s, cin_s;
  logic [7:0] err_cnt_s;
  logic [2:0] fail_op_s, fail_a_s, fail_b_s, A_s, B_s, opcode_s;
  logic       serial_in_s, direction_s, red_op_A_s, red_op_B_s, bypass_A_s, bypass_B_s;
  logic [5:0] alsu_out_s;

  alsu_bist_ctrl #(.NUM_VECTORS(N), .LATENCY(L), .FULL_ADDER("ON")) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_op(fail_op), .fail_a(fail_a), .fail_b(fail_b),
    .alsu_rst(alsu_rst), .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A),
    .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .alsu_out(alsu_out)
  );

  alsu_bist_ctrl #(.NUM_VECTORS(1), .LATENCY(1), .FULL_ADDER("ON")) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_cnt(err_cnt_s), .fail_op(fail_op_s), .fail_a(fail_a_s), .fail_b(fail_b_s),
    .alsu_rst(alsu_rst_s), .A(A_s), .B(B_s), .opcode(opcode_s), .cin(cin_s),
    .serial_in(serial_in_s), .direction(direction_s), .red_op_A(red_op_A_s),
    .red_op_B(red_op_B_s), .bypass_A(bypass_A_s), .bypass_B(bypass_B_s),
    .alsu_out(alsu_out_s)
  );

  function automatic logic [5:0] alsu_f(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic c);
    case (op)
      3'd0:    return {3'b000, a & b};
      3'd1:    return {3'b000, a ^ b};
      3'd2:    return 6'(a) + 6'(b) + 6'(c);
      3'd3:    return 6'(a) * 6'(b);
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] lfsr_step(input logic [5:0] s);
    return {s[4:0], s[5] ^ s[4]};
  endfunction

  // Behavioural ALSU: L-stage pipeline held clear while alsu_rst is high.
  logic [5:0] pipe [L];
  always @(posedge clk) begin
    if (alsu_rst) begin
      for (int i = 0; i < L; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= alsu_f(opcode, A, B, cin);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign alsu_out = (mode == 2) ? 6'd0 : (mode == 1) ? pipe[L-1] + 6'd1 : pipe[L-1];

  logic [5:0] pipe_s;
  always @(posedge clk) pipe_s <= alsu_rst_s ? 6'd0 : alsu_f(opcode_s, A_s, B_s, cin_s);
  assign alsu_out_s = pipe_s;

  vec_t sb_q[$];
  res_t res_q[$];
  tc_t  tbl[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected end-of-run result for a given ALSU fault mode.
  function automatic res_t model_res(input int m);
    res_t       r;
    logic [5:0] lf = 6'h01;
    int         errs = 0;
    r = '{cycles: RUN, pass: 1'b1, err: 8'd0, fop: 3'd0, fa: 3'd0, fb: 3'd0};
    for (int ph = 0; ph < 4; ph++) begin
      for (int v = 0; v < N; v++) begin
        logic [5:0] e, o;
        logic       c = v[0];
        e = alsu_f(3'(ph), lf[5:3], lf[2:0], c);
        o = (m == 2) ? 6'd0 : (m == 1) ? e + 6'd1 : e;
        if (o != e) begin
          if (errs == 0) begin
            r.fop = 3'(ph);
            r.fa  = lf[5:3];
            r.fb  = lf[2:0];
          end
          errs++;
        end
        lf = lfsr_step(lf);
      end
    end
    r.err  = (errs > 255) ? 8'd255 : 8'(errs);
    r.pass = (errs == 0);
    return r;
  endfunction

  task automatic push_vectors(input int nv);
    logic [5:0] lf = 6'h01;
    for (int ph = 0; ph < 4; ph++) begin
      for (int v = 0; v < nv; v++) begin
        logic c = v[0];
        sb_q.push_back('{op: 3'(ph), a: lf[5:3], b: lf[2:0], c: c});
        lf = lfsr_step(lf);
      end
    end
  endtask

  task automatic run_main(input tc_t t, input string tag);
    int   c = 0;
    vec_t e;
    res_t r;
    mode = t.mode;
    push_vectors(N);
    res_q.push_back(t.exp);
    @(negedge clk) start = 1'b1;
    forever begin
      @(posedge clk);
      c++;
      @(negedge clk);
      start = 1'b0;
      if (c == 1)
        check({tag, " cleared_on_start"}, {done, pass, err_cnt, fail_op, fail_a, fail_b, busy}, 21'd1);
      if (done || c >= BUDGET) break;
      if (((c - 1) % (L + 1)) == 0) begin
        if (sb_q.size() == 0) begin
          check({tag, " extra_vector"}, 64'(c), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check({tag, " vector"}, {opcode, A, B, cin, busy, alsu_rst, done},
                {e.op, e.a, e.b, e.c, 1'b1, 1'b0, 1'b0});
        end
      end
      start = t.pulses && ((c % 53) == 7);
    end
    r = res_q.pop_front();
    check({tag, " cycles"}, 64'(c), 64'(r.cycles));
    check({tag, " done_pass"}, {done, pass, busy, alsu_rst}, {1'b1, r.pass, 1'b0, 1'b1});
    check({tag, " err_cnt"}, err_cnt, r.err);
    check({tag, " fail_vec"}, {fail_op, fail_a, fail_b}, {r.fop, r.fa, r.fb});
    check({tag, " vectors_left"}, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    check({tag, " done_held"}, {done, busy, err_cnt}, {1'b1, 1'b0, r.err});
  endtask

  initial begin
    int   c;
    vec_t e;
    rst = 1'b0; start = 1'b0; start_s = 1'b0; mode = 0;

    tbl[0] = '{mode: 0, pulses: 1'b0,
               exp: '{cycles: 1201, pass: 1'b1, err: 8'd0, fop: 3'd0, fa: 3'd0, fb: 3'd0}};
    tbl[1] = '{mode: 1, pulses: 1'b0,
               exp: '{cycles: 1201, pass: 1'b0, err: 8'd255, fop: 3'd0, fa: 3'd0, fb: 3'd1}};
    tbl[2] = '{mode: 2, pulses: 1'b0, exp: model_res(2)};
    tbl[3] = '{mode: 0, pulses: 1'b1, exp: tbl[0].exp};

    #12;
    check("reset_state",
          {busy, done, pass, err_cnt, fail_op, fail_a, fail_b, A, B, opcode, cin, alsu_rst},
          31'd1);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    check("tied_zero", {serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}, 6'd0);
    check("idle_hold", {busy, done, alsu_rst}, 3'b001);

    foreach (tbl[i]) run_main(tbl[i], $sformatf("tc%0d", i));

    // Mid-run reset during phase 2 aborts the run.
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c = 0;
    while (opcode != 3'd2 && c < BUDGET) begin
      @(negedge clk);
      c++;
    end
    check("phase2_reached", {opcode, busy}, {3'd2, 1'b1});
    #2 rst = 1'b0;
    #1;
    check("async_reset",
          {busy, done, pass, err_cnt, fail_op, fail_a, fail_b, A, B, opcode, cin, alsu_rst},
          31'd1);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", {busy, done, alsu_rst}, 3'b001);
    run_main(tbl[0], "post_reset");

    // Shortest configuration: one vector per phase, LATENCY 1.
    push_vectors(1);
    c = 0;
    @(negedge clk) start_s = 1'b1;
    forever begin
      @(posedge clk);
      c++;
      @(negedge clk);
      start_s = 1'b0;
      if (done_s || c >= 50) break;
      if (((c - 1) % 2) == 0) begin
        if (sb_q.size() == 0) begin
          check("small extra_vector", 64'(c), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("small vector", {opcode_s, A_s, B_s, cin_s, busy_s}, {e.op, e.a, e.b, e.c, 1'b1});
        end
      end
    end
    check("small cycles", 64'(c), 64'd9);
    check("small result", {done_s, pass_s, err_cnt_s}, {1'b1, 1'b1, 8'd0});
    check("small vectors_left", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
